// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray-to-binary converter among N_REQ requesters.
// Each conversion runs IDLE -> CAPTURE -> CONV -> HOLD and is released by the consumer's ack.
module gray_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   gray_in,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic [WIDTH-1:0]         bin_out,
    output logic [ID_W-1:0]          bin_id,
    output logic                     bin_valid,
    input  logic                     ack
);

    typedef enum logic [1:0] {IDLE, CAPTURE, CONV, HOLD} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  gray_reg;
    logic [WIDTH-1:0]  gray_sel;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   sel;
    logic              found;
    int                idx;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = WIDTH - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Search upward from the requester after the last one served, wrapping around.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && req[idx[ID_W-1:0]]) begin
                sel   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    // bin_id already holds the granted index by the time CAPTURE samples the word.
    always_comb begin
        gray_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (bin_id == ID_W'(i))
                gray_sel = gray_in[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = CAPTURE;
            CAPTURE: state_next = CONV;
            CONV:    state_next = HOLD;
            HOLD:    if (ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            busy      <= 1'b0;
            bin_out   <= '0;
            bin_id    <= '0;
            bin_valid <= 1'b0;
            // NOTE: gray_reg is an ordinary register, not a memory, so it is reset with the rest.
            gray_reg  <= '0;
            last      <= ID_W'(N_REQ - 1);
        end else begin
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (found) begin
                        grant  <= N_REQ'(1) << sel;
                        bin_id <= sel;
                    end
                end
                CAPTURE: begin
                    gray_reg <= gray_sel;
                    grant    <= '0;
                end
                CONV: begin
                    bin_out   <= gray2bin(gray_reg);
                    bin_valid <= 1'b1;
                end
                HOLD: begin
                    if (ack) begin
                        bin_valid <= 1'b0;
                        last      <= bin_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_gray_conv_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;
    localparam int GW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [GW-1:0] gray_in = '0;
    logic          ack = 1'b0;
    logic [N-1:0]  grant;
    logic          busy;
    logic [W-1:0]  bin_out;
    logic [IW-1:0] bin_id;
    logic          bin_valid;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    gray_conv_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .gray_in(gray_in), .grant(grant), .busy(busy),
        .bin_out(bin_out), .bin_id(bin_id), .bin_valid(bin_valid), .ack(ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Reference: binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    // Transaction model: one conversion in flight, tracked by edges elapsed since its grant.
    bit           m_active;
    int           m_age;
    int           m_sel;
    int           m_last;
    logic [W-1:0] m_word;
    logic [W-1:0] m_out;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_sel = 0; m_last = N - 1; m_word = '0; m_out = '0;
        end else if (!m_active) begin
            if (req != '0) begin
                m_sel = rr_pick(req, m_last); m_active = 1'b1; m_age = 1;
            end
        end else if (m_age == 1) begin
            m_word = gray_in[m_sel*W +: W]; m_age = 2;
        end else if (m_age == 2) begin
            m_out = ref_g2b(m_word); m_age = 3;
        end else if (ack) begin
            m_last = m_sel; m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            check("grant",     grant,     (m_active && m_age == 1) ? (N'(1) << m_sel) : N'(0));
            check("busy",      busy,      m_active);
            check("bin_valid", bin_valid, m_active && m_age == 3);
            check("bin_out",   bin_out,   m_out);
            check("bin_id",    bin_id,    m_sel);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(output logic [N-1:0] g);
        int n = 0;
        g = '0;
        while (g == '0 && n < 40) begin
            @(negedge clk);
            g = grant;
            n++;
        end
        if (g == '0) timeout("wait_grant");
    endtask

    task automatic wait_valid();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            seen = bin_valid;
            n++;
        end
        if (!seen) timeout("wait_valid");
    endtask

    task automatic set_gray(input int i, input logic [W-1:0] g);
        gray_in[i*W +: W] = g;
    endtask

    logic [N-1:0] g;
    logic [W-1:0] tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                               4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};
    logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W-1:0] exp_r [4] = '{4'b0001, 4'b1111, 4'b1010, 4'b0100};
    logic [N-1:0] gs [5];
    logic [W-1:0] rs [4];
    int           ids [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic single conversion and reset state.
        do_reset();
        started = 1'b1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", bin_valid, 0);
        check("rst_bin_out", bin_out, 0);
        check("rst_bin_id", bin_id, 0);
        set_gray(0, 4'b0110);
        req = 4'b0001;
        wait_grant(g);
        check("t1_grant", g, 4'b0001);
        req = '0;
        @(negedge clk);
        check("t1_grant_one_cycle", grant, 0);
        wait_valid();
        check("t1_bin_out", bin_out, 4'b0100);
        check("t1_bin_id", bin_id, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t1_valid_after_ack", bin_valid, 0);
        check("t1_busy_after_ack", busy, 0);

        // Round robin over four held requesters with ack tied high.
        do_reset();
        set_gray(0, 4'b0001); set_gray(1, 4'b1000); set_gray(2, 4'b1111); set_gray(3, 4'b0110);
        req = 4'b1111;
        ack = 1'b1;
        begin
            int ng = 0;
            int nr = 0;
            for (int c = 0; c < 60 && ng < 5; c++) begin
                @(negedge clk);
                if (grant != '0) begin gs[ng] = grant; ng++; end
                if (bin_valid && nr < 4) begin rs[nr] = bin_out; ids[nr] = int'(bin_id); nr++; end
            end
            if (ng < 5 || nr < 4) timeout("t2_collect");
            for (int i = 0; i < ng; i++) check($sformatf("t2_grant%0d", i), gs[i], exp_g[i]);
            for (int i = 0; i < nr; i++) begin
                check($sformatf("t2_result%0d", i), rs[i], exp_r[i]);
                check($sformatf("t2_id%0d", i), ids[i], i);
            end
        end
        req = '0;
        repeat (6) @(negedge clk);
        ack = 1'b0;

        // Sweep every Gray code through requester 2.
        for (int code = 0; code < 16; code++) begin
            set_gray(2, code[W-1:0]);
            req = 4'b0100;
            wait_grant(g);
            req = '0;
            wait_valid();
            check($sformatf("t3_bin_%0d", code), bin_out, tbl[code]);
            check($sformatf("t3_roundtrip_%0d", code), bin_out ^ (bin_out >> 1), code);
            check($sformatf("t3_id_%0d", code), bin_id, 2);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
        end

        // Result held while ack is low; other requests wait.
        set_gray(0, 4'b0110);
        req = 4'b0001;
        wait_grant(g);
        wait_valid();
        req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t4_hold_valid", bin_valid, 1);
            check("t4_hold_bin_out", bin_out, 4'b0100);
            check("t4_hold_bin_id", bin_id, 0);
            check("t4_hold_no_grant", grant, 0);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        wait_grant(g);
        check("t4_next_grant", g, 4'b0010);
        req = '0;
        ack = 1'b1;
        repeat (6) @(negedge clk);
        ack = 1'b0;

        // Word is sampled at the edge ending the grant cycle; later changes are ignored.
        do_reset();
        set_gray(0, 4'b1100);
        req = 4'b0001;
        wait_grant(g);
        req = '0;
        @(negedge clk);
        set_gray(0, 4'b0011);
        wait_valid();
        check("t5_sampled_word", bin_out, 4'b1000);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Reset during CONV aborts the transaction.
        do_reset();
        set_gray(0, 4'b0110);
        req = 4'b0001;
        wait_grant(g);
        req = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_async_grant", grant, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_valid", bin_valid, 0);
        check("t6_async_bin_out", bin_out, 0);
        check("t6_async_bin_id", bin_id, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_no_valid_in_reset", bin_valid, 0);
        end
        req = 4'b1010;
        rst = 1'b0;
        wait_grant(g);
        check("t6_first_grant", g, 4'b0010);
        req = '0;
        ack = 1'b1;
        repeat (6) @(negedge clk);
        ack = 1'b0;

        // Randomized traffic against the model, with rare reset pulses.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req     = N'($urandom);
            gray_in = GW'($urandom);
            ack     = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        ack = 1'b1;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
